// File: rtl/wave_pkg.sv
// Shared definitions for the wave cache frame scheduler: write FSM encoding,
// channel codes and write-address field positions.
package wave_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrL,
    StWrR
  } wr_state_e;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  // WrAddr layout is {bank, channel, index[bw_frame-1:0]}.
  function automatic int unsigned chan_pos(input int unsigned bw_frame);
    return bw_frame;
  endfunction

  function automatic int unsigned bank_pos(input int unsigned bw_frame);
    return bw_frame + 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [width-1:0] count
);

  localparam logic [width-1:0] One = 1;

  logic [width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + One;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/wave_frame_scheduler.sv
// Writes stereo samples into a ping-pong wave cache and hands completed
// frames to the spectrum consumer, dropping frames it cannot accept.
module wave_frame_scheduler
  import wave_pkg::*;
#(
  parameter int unsigned bw_frame = 10,
  parameter int unsigned bw_data  = 16,
  parameter int unsigned bw_drop  = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Enable,
  input  logic                SampleValid,
  input  logic [bw_data-1:0]  SampleL,
  input  logic [bw_data-1:0]  SampleR,
  output logic                WrEn,
  output logic [bw_frame+1:0] WrAddr,
  output logic [bw_data-1:0]  WrData,
  output logic                FrameReady,
  output logic                FrameBank,
  input  logic                FrameAck,
  output logic                Busy,
  output logic [bw_drop-1:0]  DropCount
);

  localparam int unsigned BankPos = bank_pos(bw_frame);
  localparam int unsigned ChanPos = chan_pos(bw_frame);
  localparam logic [bw_frame-1:0] IndexLast = '1;
  localparam logic [bw_frame-1:0] IndexOne  = 1;

  wr_state_e           state_q, state_d;
  logic [bw_frame-1:0] index_q, index_d;
  logic                wr_bank_q, wr_bank_d;
  logic [bw_data-1:0]  lat_r_q, lat_r_d;
  logic                frame_ready_q, frame_ready_d;
  logic                frame_bank_q, frame_bank_d;
  logic                wr_en_q, wr_en_d;
  logic [bw_frame+1:0] wr_addr_q, wr_addr_d;
  logic [bw_data-1:0]  wr_data_q, wr_data_d;
  logic                drop_inc;

  function automatic logic [bw_frame+1:0] make_addr(input logic bank, input logic ch,
                                                     input logic [bw_frame-1:0] idx);
    logic [bw_frame+1:0] a;
    a = '0;
    a[BankPos] = bank;
    a[ChanPos] = ch;
    a[bw_frame-1:0] = idx;
    return a;
  endfunction

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    wr_bank_d     = wr_bank_q;
    lat_r_d       = lat_r_q;
    frame_ready_d = frame_ready_q;
    frame_bank_d  = frame_bank_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    drop_inc      = 1'b0;

    if (FrameAck && frame_ready_q) begin
      frame_ready_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (Enable && SampleValid) begin
          state_d   = StWrL;
          lat_r_d   = SampleR;
          wr_en_d   = 1'b1;
          wr_addr_d = make_addr(wr_bank_q, CH_L, index_q);
          wr_data_d = SampleL;
        end else if (!Enable) begin
          // Disabling capture discards any partial frame.
          index_d = '0;
        end
      end
      StWrL: begin
        state_d   = StWrR;
        wr_en_d   = 1'b1;
        wr_addr_d = make_addr(wr_bank_q, CH_R, index_q);
        wr_data_d = lat_r_q;
      end
      StWrR: begin
        state_d = StIdle;
        index_d = index_q + IndexOne;
        if (index_q == IndexLast) begin
          // Ack is honoured before completion, so a same-cycle ack frees the slot.
          if (!frame_ready_q || FrameAck) begin
            frame_ready_d = 1'b1;
            frame_bank_d  = wr_bank_q;
            wr_bank_d     = ~wr_bank_q;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= StIdle;
      index_q       <= '0;
      wr_bank_q     <= 1'b0;
      lat_r_q       <= '0;
      frame_ready_q <= 1'b0;
      frame_bank_q  <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      wr_bank_q     <= wr_bank_d;
      lat_r_q       <= lat_r_d;
      frame_ready_q <= frame_ready_d;
      frame_bank_q  <= frame_bank_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
    end
  end

  sat_counter #(
    .width(bw_drop)
  ) u_drop_counter (
    .clk  (Clock),
    .rst  (Reset),
    .inc  (drop_inc),
    .count(DropCount)
  );

  assign WrEn       = wr_en_q;
  assign WrAddr     = wr_addr_q;
  assign WrData     = wr_data_q;
  assign FrameReady = frame_ready_q;
  assign FrameBank  = frame_bank_q;
  assign Busy       = (state_q != StIdle);

endmodule

// File: tb/tb_wave_frame_scheduler.sv
// Directed bench for wave_frame_scheduler with 8-sample frames.
module tb_wave_frame_scheduler;

  localparam int unsigned BwFrame = 3;
  localparam int unsigned BwData  = 16;
  localparam int unsigned BwDrop  = 8;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              Enable;
  logic              SampleValid;
  logic [BwData-1:0] SampleL;
  logic [BwData-1:0] SampleR;
  logic              WrEn;
  logic [BwFrame+1:0] WrAddr;
  logic [BwData-1:0] WrData;
  logic              FrameReady;
  logic              FrameBank;
  logic              FrameAck;
  logic              Busy;
  logic [BwDrop-1:0] DropCount;

  int n_vec = 0;
  int n_bad = 0;

  wave_frame_scheduler #(
    .bw_frame(BwFrame),
    .bw_data (BwData),
    .bw_drop (BwDrop)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Enable     (Enable),
    .SampleValid(SampleValid),
    .SampleL    (SampleL),
    .SampleR    (SampleR),
    .WrEn       (WrEn),
    .WrAddr     (WrAddr),
    .WrData     (WrData),
    .FrameReady (FrameReady),
    .FrameBank  (FrameBank),
    .FrameAck   (FrameAck),
    .Busy       (Busy),
    .DropCount  (DropCount)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [31:0] addr(input logic bank, input logic ch, input int idx);
    logic [2:0] i;
    i = 3'(idx);
    return 32'({bank, ch, i});
  endfunction

  task automatic do_reset;
    Reset       = 1'b1;
    SampleValid = 1'b0;
    FrameAck    = 1'b0;
    tick;
    tick;
    Reset = 1'b0;
  endtask

  task automatic ack_pulse;
    FrameAck = 1'b1;
    tick;
    FrameAck = 1'b0;
    check("ack_clears_ready", 32'(FrameReady), 32'd0);
  endtask

  // One strobe, then its L write, R write and completion cycle; 4 cycles total.
  task automatic send(input logic [15:0] l, input logic [15:0] r, input logic bank,
                      input int idx, input logic rdy_pre, input logic rdy,
                      input logic fbank, input logic ack_wrr);
    SampleL     = l;
    SampleR     = r;
    SampleValid = 1'b1;
    tick;
    SampleValid = 1'b0;
    SampleL     = '0;
    SampleR     = '0;
    check("l_en", 32'(WrEn), 32'd1);
    check("l_addr", 32'(WrAddr), addr(bank, 1'b0, idx));
    check("l_data", 32'(WrData), 32'(l));
    check("l_busy", 32'(Busy), 32'd1);
    tick;
    check("r_en", 32'(WrEn), 32'd1);
    check("r_addr", 32'(WrAddr), addr(bank, 1'b1, idx));
    check("r_data", 32'(WrData), 32'(r));
    check("rdy_pre", 32'(FrameReady), 32'(rdy_pre));
    FrameAck = ack_wrr;
    tick;
    FrameAck = 1'b0;
    check("idle_en", 32'(WrEn), 32'd0);
    check("idle_busy", 32'(Busy), 32'd0);
    check("rdy", 32'(FrameReady), 32'(rdy));
    if (rdy) check("fbank", 32'(FrameBank), 32'(fbank));
    tick;
  endtask

  initial begin
    Enable      = 1'b0;
    SampleValid = 1'b0;
    SampleL     = '0;
    SampleR     = '0;
    FrameAck    = 1'b0;
    do_reset;
    #1;
    check("rst_wren", 32'(WrEn), 32'd0);
    check("rst_addr", 32'(WrAddr), 32'd0);
    check("rst_data", 32'(WrData), 32'd0);
    check("rst_ready", 32'(FrameReady), 32'd0);
    check("rst_fbank", 32'(FrameBank), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_drop", 32'(DropCount), 32'd0);

    // First frame into bank 0.
    Enable = 1'b1;
    for (int n = 0; n < 8; n++)
      send(16'(16'h1000 + n), 16'(16'h2000 + n), 1'b0, n, 1'b0, n == 7, 1'b0, 1'b0);

    // Ack, then second frame into bank 1.
    ack_pulse;
    for (int n = 0; n < 8; n++)
      send(16'(16'h1100 + n), 16'(16'h2100 + n), 1'b1, n, 1'b0, n == 7, 1'b1, 1'b0);
    check("f2_drop", 32'(DropCount), 32'd0);

    // No acks: frames 2 and 3 overwrite bank 1 and are dropped.
    do_reset;
    for (int n = 0; n < 8; n++)
      send(16'(16'h3000 + n), 16'(16'h4000 + n), 1'b0, n, 1'b0, n == 7, 1'b0, 1'b0);
    for (int n = 0; n < 8; n++)
      send(16'(16'h3100 + n), 16'(16'h4100 + n), 1'b1, n, 1'b1, 1'b1, 1'b0, 1'b0);
    check("drop_one", 32'(DropCount), 32'd1);
    for (int n = 0; n < 8; n++)
      send(16'(16'h3200 + n), 16'(16'h4200 + n), 1'b1, n, 1'b1, 1'b1, 1'b0, 1'b0);
    check("drop_two", 32'(DropCount), 32'd2);
    check("drop_fbank", 32'(FrameBank), 32'd0);

    // Ack coinciding with completion of frame 2.
    do_reset;
    for (int n = 0; n < 8; n++)
      send(16'(16'h5000 + n), 16'(16'h6000 + n), 1'b0, n, 1'b0, n == 7, 1'b0, 1'b0);
    for (int n = 0; n < 8; n++)
      send(16'(16'h5100 + n), 16'(16'h6100 + n), 1'b1, n, 1'b1, 1'b1, n == 7, n == 7);
    check("coinc_fbank", 32'(FrameBank), 32'd1);
    check("coinc_drop", 32'(DropCount), 32'd0);

    // Enable dropped mid-frame discards the partial frame.
    ack_pulse;
    for (int n = 0; n < 5; n++)
      send(16'(16'h7000 + n), 16'(16'h8000 + n), 1'b0, n, 1'b0, 1'b0, 1'b0, 1'b0);
    Enable      = 1'b0;
    SampleValid = 1'b1;
    tick;
    SampleValid = 1'b0;
    check("dis_wren", 32'(WrEn), 32'd0);
    check("dis_busy", 32'(Busy), 32'd0);
    tick;
    Enable = 1'b1;
    for (int n = 0; n < 8; n++)
      send(16'(16'h7100 + n), 16'(16'h8100 + n), 1'b0, n, 1'b0, n == 7, 1'b0, 1'b0);

    // Reset in WR_L, with FrameReady pending.
    SampleL     = 16'hAAAA;
    SampleR     = 16'hBBBB;
    SampleValid = 1'b1;
    tick;
    SampleValid = 1'b0;
    check("mid_wren", 32'(WrEn), 32'd1);
    check("mid_addr", 32'(WrAddr), addr(1'b1, 1'b0, 0));
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    check("mrst_wren", 32'(WrEn), 32'd0);
    check("mrst_addr", 32'(WrAddr), 32'd0);
    check("mrst_data", 32'(WrData), 32'd0);
    check("mrst_ready", 32'(FrameReady), 32'd0);
    check("mrst_fbank", 32'(FrameBank), 32'd0);
    check("mrst_busy", 32'(Busy), 32'd0);

    // Strobe held through WR_L must not start a second write.
    SampleL     = 16'h0C0C;
    SampleR     = 16'h0D0D;
    SampleValid = 1'b1;
    tick;
    check("pr_l_addr", 32'(WrAddr), addr(1'b0, 1'b0, 0));
    check("pr_l_data", 32'(WrData), 32'h0C0C);
    tick;
    SampleValid = 1'b0;
    check("pr_r_addr", 32'(WrAddr), addr(1'b0, 1'b1, 0));
    check("pr_r_data", 32'(WrData), 32'h0D0D);
    tick;
    check("pr_idle_en", 32'(WrEn), 32'd0);
    tick;
    check("pr_idle_en2", 32'(WrEn), 32'd0);
    check("pr_idle_busy", 32'(Busy), 32'd0);
    send(16'h0E0E, 16'h0F0F, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
